// File: rtl/lane_accumulator.sv
// Four-lane frame accumulator with valid/ready result hold.
// Define LANE_ACC_SATURATE_EN to clamp lanes instead of wrapping.
module lane_accumulator #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_sum1,
   input  logic [DATA_WIDTH-1:0] in_sum2,
   input  logic [DATA_WIDTH-1:0] in_sum3,
   input  logic [DATA_WIDTH-1:0] in_sum4,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_acc1,
   output logic [ACC_WIDTH-1:0]  out_acc2,
   output logic [ACC_WIDTH-1:0]  out_acc3,
   output logic [ACC_WIDTH-1:0]  out_acc4,
   output logic [7:0]            out_beats,
   output logic                  out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [ACC_WIDTH-1:0]  r_acc [4];
   logic [7:0]            r_beats;
   logic                  r_ovf;

   logic [DATA_WIDTH-1:0] w_in   [4];
   logic [ACC_WIDTH:0]    w_sum  [4];
   logic [ACC_WIDTH-1:0]  w_nacc [4];
   logic                  w_lovf;
   logic                  w_accept;
   logic                  w_take;

   assign w_in[0] = in_sum1;
   assign w_in[1] = in_sum2;
   assign w_in[2] = in_sum3;
   assign w_in[3] = in_sum4;

   // One extra bit per lane exposes the carry that marks overflow.
   always_comb begin
      w_lovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_sum[i] = {1'b0, r_acc[i]}
                  + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, w_in[i]};
`ifdef LANE_ACC_SATURATE_EN
         w_nacc[i] = w_sum[i][ACC_WIDTH] ? '1 : w_sum[i][ACC_WIDTH-1:0];
`else
         w_nacc[i] = w_sum[i][ACC_WIDTH-1:0];
`endif
         w_lovf = w_lovf | w_sum[i][ACC_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      w_accept  = 1'b0;
      w_take    = 1'b0;
      unique case (r_state)
         IDLE, ACCUM: begin
            in_ready = 1'b1;
            w_accept = in_valid;
            if (in_valid) w_next = in_last ? HOLD : ACCUM;
         end
         HOLD: begin
            out_valid = 1'b1;
            w_take    = out_ready;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || w_take) begin
         for (int i = 0; i < 4; i++) r_acc[i] <= '0;
         r_beats <= '0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         for (int i = 0; i < 4; i++) r_acc[i] <= w_nacc[i];
         if (r_beats != 8'hFF) r_beats <= r_beats + 8'd1;
         r_ovf <= r_ovf | w_lovf;
      end
   end

   assign out_acc1  = r_acc[0];
   assign out_acc2  = r_acc[1];
   assign out_acc3  = r_acc[2];
   assign out_acc4  = r_acc[3];
   assign out_beats = r_beats;
   assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_lane_accumulator.sv
// Self-checking bench for lane_accumulator: vector table plus
// scoreboard of expected frame results and multi-cycle corner cases.
module tb_lane_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_sum1 = '0, in_sum2 = '0, in_sum3 = '0, in_sum4 = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_acc1, out_acc2, out_acc3, out_acc4;
   logic [7:0]  out_beats;
   logic        out_ovf;

   lane_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(24)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum1(in_sum1), .in_sum2(in_sum2),
      .in_sum3(in_sum3), .in_sum4(in_sum4),
      .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_acc1(out_acc1), .out_acc2(out_acc2),
      .out_acc3(out_acc3), .out_acc4(out_acc4),
      .out_beats(out_beats), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0][23:0] acc;
      logic [7:0]       beats;
      logic             ovf;
   } exp_t;

   typedef struct {
      int                    nb;
      logic [2:0][3:0][15:0] s;
      exp_t                  e;
   } vec_t;

   exp_t q[$];
   int   total = 0;
   int   passed = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d,
                       input logic last);
      in_valid = 1'b1;
      in_sum1 = a; in_sum2 = b; in_sum3 = c; in_sum4 = d;
      in_last = last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!out_valid && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic check_out(input string name, input exp_t e);
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_in_ready"}, in_ready, 0);
      chk({name, "_acc1"}, out_acc1, e.acc[0]);
      chk({name, "_acc2"}, out_acc2, e.acc[1]);
      chk({name, "_acc3"}, out_acc3, e.acc[2]);
      chk({name, "_acc4"}, out_acc4, e.acc[3]);
      chk({name, "_beats"}, out_beats, e.beats);
      chk({name, "_ovf"}, out_ovf, e.ovf);
   endtask

   task automatic collect(input string name);
      exp_t e;
      wait_valid(name);
      if (q.size() == 0) begin
         chk({name, "_sb_empty"}, 0, 1);
         return;
      end
      e = q.pop_front();
      check_out(name, e);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_post_valid"}, out_valid, 0);
      chk({name, "_post_ready"}, in_ready, 1);
      chk({name, "_post_acc1"}, out_acc1, 0);
   endtask

   function automatic exp_t mk(input logic [23:0] a, input logic [23:0] b,
                               input logic [23:0] c, input logic [23:0] d,
                               input logic [7:0] n, input logic o);
      exp_t e;
      e.acc[0] = a; e.acc[1] = b; e.acc[2] = c; e.acc[3] = d;
      e.beats = n;
      e.ovf = o;
      return e;
   endfunction

   vec_t tbl [3];
   exp_t eb;

   initial begin
      tbl[0].nb = 3;
      tbl[0].s[0] = {16'd4, 16'd3, 16'd2, 16'd1};
      tbl[0].s[1] = {16'd40, 16'd30, 16'd20, 16'd10};
      tbl[0].s[2] = {16'd400, 16'd300, 16'd200, 16'd100};
      tbl[0].e = mk(24'd111, 24'd222, 24'd333, 24'd444, 8'd3, 1'b0);
      tbl[1].nb = 1;
      tbl[1].s[0] = {16'h8000, 16'd1, 16'd0, 16'hFFFF};
      tbl[1].s[1] = '0;
      tbl[1].s[2] = '0;
      tbl[1].e = mk(24'h00FFFF, 24'd0, 24'd1, 24'h008000, 8'd1, 1'b0);
      tbl[2].nb = 2;
      tbl[2].s[0] = {16'hFFFF, 16'd9, 16'd0, 16'd1};
      tbl[2].s[1] = {16'hFFFF, 16'd1, 16'd5, 16'd2};
      tbl[2].s[2] = '0;
      tbl[2].e = mk(24'd3, 24'd5, 24'd10, 24'h01FFFE, 8'd2, 1'b0);

      // reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_acc1", out_acc1, 0);
      chk("rst_acc4", out_acc4, 0);
      chk("rst_beats", out_beats, 0);
      chk("rst_ovf", out_ovf, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // table-driven frames
      for (int v = 0; v < 3; v++) begin
         for (int b = 0; b < tbl[v].nb; b++)
            beat(tbl[v].s[b][0], tbl[v].s[b][1], tbl[v].s[b][2],
                 tbl[v].s[b][3], b == tbl[v].nb - 1);
         q.push_back(tbl[v].e);
         collect($sformatf("vec%0d", v));
      end

      // backpressure: HOLD ignores in_valid
      beat(16'd9, 16'd8, 16'd7, 16'd6, 1'b1);
      eb = mk(24'd9, 24'd8, 24'd7, 24'd6, 8'd1, 1'b0);
      wait_valid("bp");
      in_valid = 1'b1;
      in_sum1 = 16'd50; in_sum2 = 16'd50;
      in_sum3 = 16'd50; in_sum4 = 16'd50;
      in_last = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check_out("bp_hold", eb);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      q.push_back(eb);
      collect("bp_rel");
      beat(16'd5, 16'd5, 16'd5, 16'd5, 1'b1);
      q.push_back(mk(24'd5, 24'd5, 24'd5, 24'd5, 8'd1, 1'b0));
      collect("bp_next");

      // overflow with beat count saturation
      for (int i = 0; i < 257; i++)
         beat(16'hFFFF, 16'd0, 16'd0, 16'd0, i == 256);
`ifdef LANE_ACC_SATURATE_EN
      q.push_back(mk(24'hFFFFFF, 24'd0, 24'd0, 24'd0, 8'd255, 1'b1));
`else
      q.push_back(mk(24'h00FEFF, 24'd0, 24'd0, 24'd0, 8'd255, 1'b1));
`endif
      collect("ovf");

      // reset mid-frame discards partial totals
      beat(16'd7, 16'd7, 16'd7, 16'd7, 1'b0);
      beat(16'd7, 16'd7, 16'd7, 16'd7, 1'b0);
      chk("mid_acc1_pre", out_acc1, 14);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_acc1", out_acc1, 0);
      chk("mid_beats", out_beats, 0);
      chk("mid_in_ready", in_ready, 1);
      beat(16'd1, 16'd0, 16'd0, 16'd0, 1'b1);
      q.push_back(mk(24'd1, 24'd0, 24'd0, 24'd0, 8'd1, 1'b0));
      collect("mid");

      // reset wins over a pending output handshake
      beat(16'd3, 16'd3, 16'd3, 16'd3, 1'b1);
      wait_valid("rhs");
      rst = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b0;
      chk("rhs_valid", out_valid, 0);
      chk("rhs_acc1", out_acc1, 0);
      chk("rhs_in_ready", in_ready, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lane_accumulator.md
# lane_accumulator

Four-lane accumulator that sits directly downstream of the registered 4-lane adder stage. Each accepted beat adds one set of four unsigned lane sums into widened running totals. A beat flagged `in_last` closes the frame. The four totals, a beat count and an overflow flag are then held for the consumer behind a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 16, width of each incoming lane sum (unsigned)
- `ACC_WIDTH`, 24, width of each accumulator; must be ≥ `DATA_WIDTH`
- `clk` input 1: sole clock; all logic on the rising edge
- `rst` input 1: reset, synchronous, active-high
- `in_valid` input 1: the current beat's lane sums and `in_last` are valid
- `in_ready` output 1: block can accept a beat
- `in_sum1`..`in_sum4` input `DATA_WIDTH` each: lane sums from the adder stage
- `in_last` input 1: final beat of the frame; sampled only on an accepted beat
- `out_valid` output 1: frame result is presented
- `out_ready` input 1: consumer takes the result
- `out_acc1`..`out_acc4` output `ACC_WIDTH` each: per-lane frame totals
- `out_beats` output 8: accepted beats in the frame, saturating at 255
- `out_ovf` output 1: sticky flag, set if any lane exceeded `2^ACC_WIDTH-1` during the frame

## Operation
- **States**
  - IDLE: totals zero, no beats yet.
  - ACCUM: at least one beat accepted, no last yet.
  - HOLD: result presented.
- **Accept** = `in_valid && in_ready`. `in_ready` = 1 in IDLE and ACCUM, 0 in HOLD.
- **Accepted beat, `in_last`=0**
  - Each `acc_i` becomes `acc_i` + zero-extended `in_sum_i`.
  - `out_beats` increments, saturating at 255.
  - IDLE→ACCUM; ACCUM stays ACCUM.
- **Accepted beat, `in_last`=1**
  - Same update as above.
  - IDLE/ACCUM→HOLD.
- **Overflow**: if any lane's full-precision sum exceeds `2^ACC_WIDTH-1`, `out_ovf` is set and stays set until the frame ends.
- **Outputs**
  - `out_acc_i`, `out_beats` and `out_ovf` are the registered state at all times.
  - They are meaningful only while `out_valid`=1.
  - `out_valid` = 1 exactly in HOLD.
- **HOLD with `out_ready`=1**
  - Transition to IDLE.
  - Totals, `out_beats` and `out_ovf` clear to 0.
- **HOLD with `out_ready`=0**: all outputs stable; `in_valid` ignored.
- `in_valid`=0 in any state: no change.
- **Reset** (any state, including mid-frame or in HOLD)
  - Next state IDLE.
  - All accumulators, `out_beats` and `out_ovf` cleared; the partial frame is discarded.
  - Reset values: `out_valid`=0, `in_ready`=1, `out_acc1`..4=0, `out_beats`=0, `out_ovf`=0.

## Timing
- One beat per cycle is accepted while in IDLE/ACCUM.
- Latency: the last beat is accepted at edge N; `out_valid`=1 from cycle N+1 with final totals.
- Output handshake completes at the edge where `out_valid && out_ready`; `in_ready`=1 from the next cycle.
- Minimum frame period: beats + 1 cycles; `in_ready` is never high in HOLD (no bypass).
- `out_valid` is never deasserted without a handshake or reset.
- Simultaneous `rst` with any handshake: reset wins.

## Configuration
- `LANE_ACC_SATURATE_EN` defined:
  - A lane whose sum exceeds `2^ACC_WIDTH-1` clamps to `2^ACC_WIDTH-1`.
  - It stays clamped for the rest of the frame.
  - `out_ovf` is set.
- Not defined:
  - Lanes wrap modulo `2^ACC_WIDTH`.
  - `out_ovf` is still set on any wrap.

## Test plan
- **Reset**: hold `rst`=1 two cycles → `out_valid`=0, `in_ready`=1, `out_acc1`..4=0, `out_beats`=0, `out_ovf`=0.
- **3-beat frame**: beats (1,2,3,4), (10,20,30,40), (100,200,300,400), `in_last` on the third → next cycle `out_valid`=1, outputs (111,222,333,444), `out_beats`=3, `in_ready`=0.
- **Backpressure**: keep `out_ready`=0 five cycles while driving `in_valid`=1 → outputs unchanged, no beat accepted. Raise `out_ready` → next cycle `out_valid`=0, `in_ready`=1; the next 1-beat frame of (5,5,5,5) yields (5,5,5,5).
- **Overflow**: `ACC_WIDTH`=24, 257 beats with lane1=0xFFFF, others 0 → `out_beats`=255, `out_ovf`=1.
  - Lane1=0x00FEFF without `LANE_ACC_SATURATE_EN`.
  - Lane1=0xFFFFFF with it.
- **Reset mid-frame**: accept (7,7,7,7) twice, assert `rst` one cycle, then a 1-beat last frame (1,0,0,0) → (1,0,0,0), `out_beats`=1.
- **Single-beat frame**: (0xFFFF, 0, 1, 0x8000) with `in_last` from IDLE → (0x00FFFF, 0, 1, 0x008000), `out_beats`=1, `out_ovf`=0.
